// File: rtl/lan_spi_slave.sv
// SPI mode-0 responder for the LAN end of the link: decodes RCR/WCR/BFS/BFC/SRC
// against a 32 x 8 register file that local logic can also read and write.
module lan_spi_slave (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCLK_to_the_LAN,
  input  logic       SS_n_to_the_LAN,
  input  logic       MOSI_to_the_LAN,
  output logic       MISO_from_the_LAN,
  input  logic [4:0] host_addr,
  output logic [7:0] host_rdata,
  input  logic       host_we,
  input  logic [7:0] host_wdata,
  output logic       wr_strobe,
  output logic [4:0] wr_addr
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_IGNORE} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_sclk_s, r_ss_s, r_mosi_s;
  logic        r_sclk_d, r_armed;
  logic [6:0]  r_rx;
  logic [7:0]  r_tx;
  logic [2:0]  r_cnt, r_op;
  logic [4:0]  r_addr;
  logic [7:0]  r_regs [32];
  logic        r_wr_strobe;
  logic [4:0]  r_wr_addr;

  logic        w_sclk, w_ss_n, w_mosi, w_rise, w_fall, w_active, w_byte_done;
  logic        w_cmd_known, w_is_rcr;
  logic [7:0]  w_byte, w_spi_wdata;
  logic        w_spi_we, w_src, w_load_cmd, w_reload, w_miso_en;

  assign w_sclk      = r_sclk_s[1];
  assign w_ss_n      = r_ss_s[1];
  assign w_mosi      = r_mosi_s[1];
  assign w_rise      = w_sclk & ~r_sclk_d;
  assign w_fall      = ~w_sclk & r_sclk_d;
  assign w_active    = (r_state != S_IDLE) && !w_ss_n;
  assign w_byte_done = w_active && w_rise && (r_cnt == 3'd7);
  assign w_byte      = {r_rx, w_mosi};
  assign w_cmd_known = (w_byte[7:5] == 3'b000) || (w_byte[7:5] == 3'b010) ||
                       (w_byte[7:5] == 3'b100) || (w_byte[7:5] == 3'b101);
  assign w_is_rcr    = (r_op == 3'b000);

  // Sync flops reset to 0 so r_armed only sets once SS_n is genuinely seen high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_s <= '0;
      r_ss_s   <= '0;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], SCLK_to_the_LAN};
      r_ss_s   <= {r_ss_s[0], SS_n_to_the_LAN};
      r_mosi_s <= {r_mosi_s[0], MOSI_to_the_LAN};
      r_sclk_d <= r_sclk_s[1];
      r_armed  <= r_armed | w_ss_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_ss_n) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (r_armed) w_next = S_CMD;
        S_CMD:    if (w_byte_done) w_next = w_cmd_known ? S_DATA : S_IGNORE;
        S_DATA:   if (w_byte_done && !w_is_rcr) w_next = S_IGNORE;
        default:  w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_spi_we   = 1'b0;
    w_src      = 1'b0;
    w_load_cmd = 1'b0;
    w_reload   = 1'b0;
    w_miso_en  = 1'b0;
    case (r_state)
      S_CMD: begin
        w_load_cmd = w_byte_done;
        w_src      = w_byte_done && (w_byte == 8'hFF);
      end
      S_DATA: begin
        w_miso_en = w_is_rcr;
        w_reload  = w_byte_done && w_is_rcr;
        w_spi_we  = w_byte_done && !w_is_rcr;
      end
      default: ;
    endcase
  end

  // TX only shifts mid-byte, so the fall right after a (re)load keeps bit 7.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx   <= '0;
      r_cnt  <= '0;
      r_tx   <= '0;
      r_op   <= '0;
      r_addr <= '0;
    end else if (w_ss_n) begin
      r_rx  <= '0;
      r_cnt <= '0;
    end else if (w_active) begin
      if (w_rise) begin
        r_rx  <= w_byte[6:0];
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_load_cmd) begin
        r_op   <= w_byte[7:5];
        r_addr <= w_byte[4:0];
        r_tx   <= r_regs[w_byte[4:0]];
      end else if (w_reload) begin
        r_tx <= r_regs[r_addr];
      end else if (w_fall && (r_cnt != 3'd0)) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
    end
  end

  always_comb begin
    case (r_op)
      3'b100:  w_spi_wdata = r_regs[r_addr] | w_byte;
      3'b101:  w_spi_wdata = r_regs[r_addr] & ~w_byte;
      default: w_spi_wdata = w_byte;
    endcase
  end

  // SPI write is last so it wins a same-address collision with the host.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_src) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      if (host_we)  r_regs[host_addr] <= host_wdata;
      if (w_spi_we) r_regs[r_addr]    <= w_spi_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_wr_strobe <= w_spi_we;
      if (w_spi_we) r_wr_addr <= r_addr;
    end
  end

  assign host_rdata        = r_regs[host_addr];
  assign wr_strobe         = r_wr_strobe;
  assign wr_addr           = r_wr_addr;
  assign MISO_from_the_LAN = w_miso_en & r_tx[7] & ~SS_n_to_the_LAN;

endmodule

// File: tb/tb_lan_spi_slave.sv
// Self-checking bench for lan_spi_slave: table of single transactions, hand-built
// corner sequences, then random transactions against a register-file model.
module tb_lan_spi_slave;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic       miso;
  logic [4:0] host_addr = '0;
  logic [7:0] host_rdata;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = '0;
  logic       wr_strobe;
  logic [4:0] wr_addr;

  int n_chk = 0, n_pass = 0;
  int strb_cnt = 0, wide_err = 0;
  logic prev_strb = 1'b0;
  logic [4:0] last_wa = '0;
  logic [7:0] m_regs [32];

  lan_spi_slave dut (
    .clk(clk), .reset(reset),
    .SCLK_to_the_LAN(sclk), .SS_n_to_the_LAN(ss_n), .MOSI_to_the_LAN(mosi),
    .MISO_from_the_LAN(miso),
    .host_addr(host_addr), .host_rdata(host_rdata), .host_we(host_we),
    .host_wdata(host_wdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strb_cnt++;
      last_wa = wr_addr;
      if (prev_strb) wide_err++;
    end
    prev_strb = (wr_strobe === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; host_we = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    host_addr = a;
    #1;
    v = host_rdata;
  endtask

  task automatic spi_begin();
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1; mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    repeat (HALF) @(negedge clk);
    m = miso;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n);
    logic m;
    for (int i = 7; i > 7 - n; i--) spi_bit(tx[i], m);
  endtask

  // Last bit of a byte with a host write landing on the byte-completion clock.
  task automatic spi_bit_host(input logic b, input logic [4:0] a, input logic [7:0] d);
    mosi = b;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    host_write(a, d);
    repeat (HALF - 3) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Reference: what one SPI transaction does to the register map.
  task automatic model_txn(input logic [7:0] cmd, input logic [7:0] d0, output logic [7:0] exp_rd,
                           output int strb);
    logic [4:0] a;
    a = cmd[4:0];
    exp_rd = m_regs[a];
    strb = 0;
    if (cmd == 8'hFF) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    end else begin
      case (cmd[7:5])
        3'b010: begin m_regs[a] = d0; strb = 1; end
        3'b100: begin m_regs[a] = m_regs[a] | d0; strb = 1; end
        3'b101: begin m_regs[a] = m_regs[a] & ~d0; strb = 1; end
        default: ;
      endcase
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] d0;
    logic [7:0] pre;
    logic [7:0] exp_val;
    logic [7:0] exp_miso;
    int         exp_strb;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [7:0] v, r0, r1, r2, junk, exp_rd;
    int s0, errs, strb_base, exp_strb, st;
    logic [7:0] d [3];
    logic [2:0] unk [4];

    vt[0] = '{cmd: 8'h03, d0: 8'h00, pre: 8'hA5, exp_val: 8'hA5, exp_miso: 8'hA5, exp_strb: 0};
    vt[1] = '{cmd: 8'h45, d0: 8'h3C, pre: 8'h00, exp_val: 8'h3C, exp_miso: 8'h00, exp_strb: 1};
    vt[2] = '{cmd: 8'h87, d0: 8'h0F, pre: 8'hF0, exp_val: 8'hFF, exp_miso: 8'h00, exp_strb: 1};
    vt[3] = '{cmd: 8'hA7, d0: 8'h81, pre: 8'hFF, exp_val: 8'h7E, exp_miso: 8'h00, exp_strb: 1};
    vt[4] = '{cmd: 8'h2A, d0: 8'h55, pre: 8'h66, exp_val: 8'h66, exp_miso: 8'h00, exp_strb: 0};
    vt[5] = '{cmd: 8'h5F, d0: 8'h99, pre: 8'h00, exp_val: 8'h99, exp_miso: 8'h00, exp_strb: 1};

    do_reset();
    chk("reset_miso", {31'd0, miso}, 32'd0);
    chk("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("reset_wr_addr", {27'd0, wr_addr}, 32'd0);
    rd(5'd0, v);  chk("reset_reg0", {24'd0, v}, 32'd0);
    rd(5'd31, v); chk("reset_reg31", {24'd0, v}, 32'd0);
    @(negedge clk);

    foreach (vt[k]) begin
      host_write(vt[k].cmd[4:0], vt[k].pre);
      s0 = strb_cnt;
      spi_begin();
      spi_byte(vt[k].cmd, junk);
      spi_byte(vt[k].d0, r0);
      spi_byte(8'hFF, r1);
      spi_end();
      chk($sformatf("tbl%0d_miso", k), {24'd0, r0}, {24'd0, vt[k].exp_miso});
      rd(vt[k].cmd[4:0], v);
      chk($sformatf("tbl%0d_reg", k), {24'd0, v}, {24'd0, vt[k].exp_val});
      chk($sformatf("tbl%0d_strobes", k), strb_cnt - s0, vt[k].exp_strb);
      if (vt[k].exp_strb != 0) chk($sformatf("tbl%0d_wr_addr", k), {27'd0, last_wa}, {27'd0, vt[k].cmd[4:0]});
      @(negedge clk);
    end

    // RCR held over three data bytes while the host rewrites the register.
    host_write(5'd31, 8'h11);
    s0 = strb_cnt;
    spi_begin();
    spi_byte(8'h1F, junk);
    fork
      spi_byte(8'h00, r0);
      begin repeat (40) @(negedge clk); host_write(5'd31, 8'h22); end
    join
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    spi_end();
    chk("rcr_hold_b0", {24'd0, r0}, 32'h11);
    chk("rcr_hold_b1", {24'd0, r1}, 32'h22);
    chk("rcr_hold_b2", {24'd0, r2}, 32'h22);
    chk("rcr_hold_strobes", strb_cnt - s0, 0);

    // WCR aborted mid-byte, then a clean read of the same register.
    host_write(5'd2, 8'h77);
    s0 = strb_cnt;
    spi_begin();
    spi_byte(8'h42, junk);
    spi_bits(8'hAA, 4);
    spi_end();
    rd(5'd2, v);
    chk("abort_reg2", {24'd0, v}, 32'h77);
    chk("abort_strobes", strb_cnt - s0, 0);
    @(negedge clk);
    spi_begin();
    spi_byte(8'h02, junk);
    spi_byte(8'h00, r0);
    spi_end();
    chk("after_abort_rcr", {24'd0, r0}, 32'h77);

    // SRC completing in the same clock as a host write.
    spi_begin();
    spi_bits(8'hFF, 7);
    spi_bit_host(1'b1, 5'd9, 8'h55);
    spi_end();
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      rd(i[4:0], v);
      if (v != 8'h00) errs++;
    end
    chk("src_all_clear", errs, 0);
    rd(5'd9, v);
    chk("src_reg9", {24'd0, v}, 32'd0);
    @(negedge clk);

    // SPI WCR and host write to reg4 in the same clock: SPI wins.
    s0 = strb_cnt;
    spi_begin();
    spi_byte(8'h44, junk);
    spi_bits(8'h12, 7);
    spi_bit_host(1'b0, 5'd4, 8'h34);
    spi_end();
    rd(5'd4, v);
    chk("collide_reg4", {24'd0, v}, 32'h12);
    chk("collide_strobes", strb_cnt - s0, 1);
    chk("collide_wr_addr", {27'd0, last_wa}, 32'd4);
    @(negedge clk);

    // Reset mid-transfer: bytes sent before SS_n toggles must be ignored.
    s0 = strb_cnt;
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h46, 4);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h46, junk);
    spi_byte(8'h5A, junk);
    spi_end();
    rd(5'd6, v);
    chk("rst_mid_reg6", {24'd0, v}, 32'd0);
    chk("rst_mid_strobes", strb_cnt - s0, 0);
    @(negedge clk);
    spi_begin();
    spi_byte(8'h46, junk);
    spi_byte(8'h5A, junk);
    spi_end();
    rd(5'd6, v);
    chk("rst_mid_recover_reg6", {24'd0, v}, 32'h5A);
    @(negedge clk);

    // Random transactions against the model.
    do_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    strb_base = strb_cnt;
    exp_strb = 0;
    unk[0] = 3'b001; unk[1] = 3'b011; unk[2] = 3'b110; unk[3] = 3'b111;
    for (int t = 0; t < 40; t++) begin
      int kind, nd;
      logic [7:0] cmd;
      kind = $urandom_range(0, 5);
      cmd[4:0] = 5'($urandom_range(0, 31));
      if (kind == 0) begin
        v = 8'($urandom);
        host_write(cmd[4:0], v);
        m_regs[cmd[4:0]] = v;
      end else begin
        case (kind)
          1: cmd[7:5] = 3'b000;
          2: cmd[7:5] = 3'b010;
          3: cmd[7:5] = 3'b100;
          4: cmd[7:5] = 3'b101;
          default: cmd[7:5] = unk[$urandom_range(0, 3)];
        endcase
        nd = $urandom_range(1, 3);
        for (int j = 0; j < 3; j++) d[j] = 8'($urandom);
        model_txn(cmd, d[0], exp_rd, st);
        exp_strb += st;
        spi_begin();
        spi_byte(cmd, junk);
        for (int j = 0; j < nd; j++) begin
          spi_byte(d[j], r0);
          if (cmd[7:5] == 3'b000) chk($sformatf("rnd%0d_rcr_b%0d", t, j), {24'd0, r0}, {24'd0, exp_rd});
        end
        spi_end();
      end
      chk($sformatf("rnd%0d_strobes", t), strb_cnt - strb_base, exp_strb);
      rd(cmd[4:0], v);
      chk($sformatf("rnd%0d_reg", t), {24'd0, v}, {24'd0, m_regs[cmd[4:0]]});
      @(negedge clk);
    end
    chk("strobe_width", wide_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
